// File: rtl/jtframe_rom_arb.sv
`default_nettype none
// ============================================================================
// jtframe_rom_arb
// NCH-channel ROM line-cache arbiter feeding a single 32-bit SDRAM read port.
// Optional: JTFRAME_ROMARB_RR_EN selects round-robin grant (default: fixed priority).
// Revision: 1.0
// ============================================================================
module jtframe_rom_arb #(
    parameter int                NCH       = 2,
    parameter int                AW        = 15,
    parameter logic [NCH*22-1:0] OFFSET    = '0,
    parameter bit                INVERT_A0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH-1:0]    ch_cs,
    output logic [NCH-1:0]    ch_ok,
    output logic [NCH*8-1:0]  ch_dout,
    input  logic              downloading,
    input  logic              loop_rst,
    output logic              ready,
    output logic              refresh_en,
    output logic              sdram_req,
    input  logic              sdram_ack,
    output logic [21:0]       sdram_addr,
    input  logic              data_rdy,
    input  logic [31:0]       data_read
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = AW - 2;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_ACK  = 2'd1;
    localparam logic [1:0] c_WAIT_DATA = 2'd2;

    logic            clr;
    logic [1:0]      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [TW-1:0]   line_q, line_d;
    logic            req_q, req_d;
    logic [21:0]     addr_q, addr_d;
    logic            refresh_q;
    logic [3:0]      rdy_sh_q;
    logic            ready_q;
    logic [NCH-1:0]  valid_q;
    logic [TW-1:0]   tag_q  [NCH];
    logic [31:0]     data_q [NCH];

    logic [NCH-1:0]  hit;
    logic [NCH-1:0]  miss;
    logic            busy;
    logic            fill;
    logic            any_miss;
    logic [GW-1:0]   pick;
    logic [TW-1:0]   pick_line;
    logic [21:0]     pick_base;

    assign clr      = downloading | loop_rst;
    assign busy     = (state_q != c_IDLE);
    assign any_miss = |miss;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [AW-1:0] addr;
        logic [1:0]    sel;

        assign addr     = ch_addr[AW*n +: AW];
        assign hit[n]   = valid_q[n] && (tag_q[n] == addr[AW-1:2]);
        // The channel being fetched must not re-request its own line.
        assign miss[n]  = ch_cs[n] && !hit[n] && !(busy && (grant_q == GW'(n)));
        assign ch_ok[n] = ch_cs[n] && hit[n];
        assign sel      = {addr[1], addr[0] ^ INVERT_A0};
        assign ch_dout[8*n +: 8] = data_q[n][{sel, 3'b000} +: 8];
    end

`ifdef JTFRAME_ROMARB_RR_EN
    logic [GW-1:0] rr_q;

    always_comb begin
        int idx;
        idx  = 0;
        pick = rr_q;
        for (int k = NCH; k >= 1; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (miss[idx]) pick = GW'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (clr) begin
            rr_q <= '0;
        end else if (state_q == c_IDLE && any_miss) begin
            rr_q <= pick;
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (miss[k]) pick = GW'(k);
        end
    end
`endif

    always_comb begin
        pick_line = '0;
        pick_base = '0;
        for (int k = 0; k < NCH; k++) begin
            if (pick == GW'(k)) begin
                pick_line = ch_addr[AW*k+2 +: TW];
                pick_base = OFFSET[22*k +: 22];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        line_d  = line_q;
        req_d   = req_q;
        addr_d  = addr_q;
        fill    = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (any_miss) begin
                    grant_d = pick;
                    line_d  = pick_line;
                    addr_d  = pick_base + 22'({pick_line, 1'b0});
                    req_d   = 1'b1;
                    state_d = c_WAIT_ACK;
                end
            end
            c_WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    // Some controllers return data in the very acknowledge cycle.
                    if (data_rdy) begin
                        fill    = 1'b1;
                        state_d = c_IDLE;
                    end else begin
                        state_d = c_WAIT_DATA;
                    end
                end
            end
            c_WAIT_DATA: begin
                if (data_rdy) begin
                    fill    = 1'b1;
                    state_d = c_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_IDLE;
            grant_q   <= '0;
            line_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
            rdy_sh_q  <= '0;
            ready_q   <= 1'b0;
            valid_q   <= '0;
            for (int n = 0; n < NCH; n++) begin
                tag_q[n]  <= '0;
                data_q[n] <= '0;
            end
        end else if (clr) begin
            state_q   <= c_IDLE;
            grant_q   <= '0;
            line_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
            rdy_sh_q  <= '0;
            ready_q   <= 1'b0;
            valid_q   <= '0;
            for (int n = 0; n < NCH; n++) begin
                tag_q[n]  <= '0;
                data_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            line_q    <= line_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            refresh_q <= !busy && !any_miss;
            rdy_sh_q  <= {rdy_sh_q[2:0], 1'b1};
            ready_q   <= rdy_sh_q[3];
            // The fill uses the latched line even if the channel has moved on.
            for (int n = 0; n < NCH; n++) begin
                if (fill && grant_q == GW'(n)) begin
                    valid_q[n] <= 1'b1;
                    tag_q[n]   <= line_q;
                    data_q[n]  <= data_read;
                end
            end
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = refresh_q;
    assign ready      = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_rom_arb.sv
`default_nettype none
// tb_jtframe_rom_arb: randomized traffic against a transaction-level model of
// the per-channel line caches, the miss arbitration and the SDRAM handshake.
module tb_jtframe_rom_arb;

    localparam int NCH = 2;
    localparam int AW  = 15;
    localparam logic [NCH*22-1:0] OFFSET = {22'h004000, 22'h3FC000};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     a [NCH];
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_cs;
    logic [NCH-1:0]    ch_ok;
    logic [NCH*8-1:0]  ch_dout;
    logic              downloading, loop_rst, ready, refresh_en;
    logic              sdram_req, sdram_ack, data_rdy;
    logic [21:0]       sdram_addr;
    logic [31:0]       data_read;

    assign ch_addr = {a[1], a[0]};

    always #5 clk = ~clk;

    jtframe_rom_arb #(
        .NCH       (NCH),
        .AW        (AW),
        .OFFSET    (OFFSET),
        .INVERT_A0 (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_addr     (ch_addr),
        .ch_cs       (ch_cs),
        .ch_ok       (ch_ok),
        .ch_dout     (ch_dout),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .ready       (ready),
        .refresh_en  (refresh_en),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_addr  (sdram_addr),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    // Reference model state
    int          off_of [NCH] = '{32'h3FC000, 32'h004000};
    bit          m_valid [NCH];
    logic [12:0] m_tag   [NCH];
    logic [31:0] m_data  [NCH];
    bit          m_busy, m_acked, m_req, m_refresh;
    int          m_g, m_rr, m_since;
    logic [12:0] m_line;
    logic [21:0] m_addr;

    // Stimulus state
    logic [12:0] pool [NCH][4];
    int          post_clr = 0;
    int          dl_cnt   = 0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int n);
        return m_valid[n] && (m_tag[n] == a[n][14:2]);
    endfunction

    // Byte lane with the A0 inversion: lane = 2*A1 + !A0
    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [14:0] ad);
        int lane;
        lane = 2 * int'(ad[1]) + (ad[0] ? 0 : 1);
        return 8'((d >> (8 * lane)) & 32'hFF);
    endfunction

    function automatic int choose(input bit [NCH-1:0] miss);
`ifdef JTFRAME_ROMARB_RR_EN
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (miss[c]) return c;
        end
        return 0;
`else
        for (int k = 0; k < NCH; k++) begin
            if (miss[k]) return k;
        end
        return 0;
`endif
    endfunction

    task automatic model_clear();
        for (int n = 0; n < NCH; n++) begin
            m_valid[n] = 1'b0;
            m_tag[n]   = '0;
            m_data[n]  = '0;
        end
        m_busy = 0; m_acked = 0; m_req = 0; m_refresh = 0;
        m_g = 0; m_rr = 0; m_since = 0; m_line = '0; m_addr = '0;
    endtask

    task automatic model_fill();
        m_valid[m_g] = 1'b1;
        m_tag[m_g]   = m_line;
        m_data[m_g]  = data_read;
        m_busy  = 0;
        m_acked = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_update();
        bit [NCH-1:0] miss;
        int g;
        if (downloading || loop_rst) begin
            model_clear();
            return;
        end
        if (m_since < 15) m_since++;
        for (int n = 0; n < NCH; n++)
            miss[n] = ch_cs[n] && !m_hit(n) && !(m_busy && m_g == n);
        m_refresh = !m_busy && (miss == '0);
        if (!m_busy) begin
            if (miss != '0) begin
                g       = choose(miss);
                m_g     = g;
                m_line  = a[g][14:2];
                m_busy  = 1;
                m_acked = 0;
                m_req   = 1;
                m_addr  = 22'((off_of[g] + 2 * int'(m_line)) % (1 << 22));
                m_rr    = g;
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                m_req = 0;
                if (data_rdy) model_fill();
                else m_acked = 1;
            end
        end else if (data_rdy) begin
            model_fill();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (m_busy && !m_acked) begin
            sdram_ack = 1'($urandom_range(0, 1));
            data_rdy  = sdram_ack && ($urandom_range(0, 3) == 0);
        end else if (m_busy) begin
            data_rdy = ($urandom_range(0, 2) == 0);
        end else if (post_clr > 0) begin
            data_rdy = 1'($urandom_range(0, 1));
        end
        if (post_clr > 0) post_clr--;
        data_read = rd_fixed_en ? rd_fixed : $urandom;
    endtask

    task automatic sample();
        bit [NCH-1:0] eok;
        @(negedge clk);
        for (int n = 0; n < NCH; n++) eok[n] = ch_cs[n] && m_hit(n);
        check_eq("ch_ok", 32'(ch_ok), 32'(eok));
        for (int n = 0; n < NCH; n++)
            check_eq($sformatf("ch_dout%0d", n), 32'(ch_dout[8*n +: 8]), 32'(byte_of(m_data[n], a[n])));
        check_eq("sdram_req", 32'(sdram_req), 32'(m_req));
        check_eq("sdram_addr", 32'(sdram_addr), 32'(m_addr));
        check_eq("ready", 32'(ready), 32'(m_since >= 5));
        check_eq("refresh_en", 32'(refresh_en), 32'(m_refresh));
    endtask

    task automatic rand_inputs();
        for (int n = 0; n < NCH; n++) begin
            if ($urandom_range(0, 3) == 0) ch_cs[n] = ~ch_cs[n];
            if ($urandom_range(0, 4) == 0)
                a[n] = {pool[n][$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 99) == 0) pool[n][$urandom_range(0, 3)] = 13'($urandom);
        end
        loop_rst = ($urandom_range(0, 79) == 0);
        if (dl_cnt > 0) begin
            downloading = 1'b1;
            dl_cnt--;
        end else begin
            downloading = 1'b0;
            if ($urandom_range(0, 249) == 0) dl_cnt = $urandom_range(1, 6);
        end
        if (loop_rst || downloading) post_clr = 4;
    endtask

    logic [14:0] t2_addr [4] = '{15'h104, 15'h105, 15'h106, 15'h107};
    logic [7:0]  t2_exp  [4] = '{8'hBB, 8'hAA, 8'hDD, 8'hCC};

    initial begin
        int  budget;
        bit  got_req;
        rst_n = 1'b0;
        ch_cs = '0;
        a[0] = '0;
        a[1] = '0;
        downloading = 1'b0;
        loop_rst    = 1'b0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        data_read   = '0;
        for (int n = 0; n < NCH; n++)
            for (int k = 0; k < 4; k++) pool[n][k] = 13'($urandom);
        model_clear();

        repeat (2) @(posedge clk);
        sample();
        rst_n = 1'b1;

        // Idle after reset: ready after the fifth edge, no requests
        repeat (6) begin
            step();
            sample();
        end

        // Channel 1 line fetch with a known data word
        rd_fixed_en = 1'b1;
        rd_fixed    = 32'hDDCCBBAA;
        a[1]  = 15'h0106;
        ch_cs = 2'b10;
        budget  = 0;
        got_req = 1'b0;
        while (!ch_ok[1] && budget < 60) begin
            step();
            sample();
            if (sdram_req && !got_req) begin
                got_req = 1'b1;
                check_eq("t2_sdram_addr", 32'(sdram_addr), 32'h004082);
            end
            budget++;
        end
        check_eq("t2_fill_in_time", 32'(ch_ok[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            a[1] = t2_addr[i];
            step();
            sample();
            check_eq("t2_dout", 32'(ch_dout[15:8]), 32'(t2_exp[i]));
            check_eq("t2_no_req", 32'(sdram_req), 32'd0);
        end
        rd_fixed_en = 1'b0;

        repeat (3000) begin
            step();
            rand_inputs();
            sample();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
